// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one single-port memory between fetch and load/store,
// sequencing each access over a fixed MEM_LAT window and building SB/SH/SW lanes.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic             owner_ls;
    logic             err_q;
    logic             if_rvalid_q;
    logic             ls_rvalid_q;
    logic             ls_err_q;
    logic [31:0]      if_rdata_q;
    logic [31:0]      ls_rdata_q;
    logic             starved;
    logic             fire;
    logic             ls_misalign;
    logic [3:0]       ls_be;
    logic [31:0]      ls_lanes;
    logic             unused_if_addr_lsbs;

    assign unused_if_addr_lsbs = ^if_addr[1:0];
    assign starved = (starve_cnt == STV_W'(STARVE_MAX));

    // Grants are gated by reset_n so every output reads 0 while reset is held.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (reset_n && state == IDLE) begin
            if_gnt = if_req && (!ls_req || starved);
            ls_gnt = ls_req && !if_gnt;
        end
    end

    always_comb begin
        ls_misalign = 1'b0;
        ls_be       = 4'b1111;
        ls_lanes    = ls_wdata;
        case (ls_size)
            2'd0: begin
                ls_be    = 4'b0001 << ls_addr[1:0];
                ls_lanes = {4{ls_wdata[7:0]}};
            end
            2'd1: begin
                ls_be       = ls_addr[1] ? 4'b1100 : 4'b0011;
                ls_lanes    = {2{ls_wdata[15:0]}};
                ls_misalign = ls_addr[0];
            end
            2'd2:    ls_misalign = (ls_addr[1:0] != 2'b00);
            default: ls_misalign = 1'b1;
        endcase
    end

    // rvalid is registered one cycle early so it lines up with the cycle mem_rdata is valid.
    assign fire = (state == ISSUE && MEM_LAT == 1) || (state == WAIT && lat_cnt == CNT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            owner_ls    <= 1'b0;
            err_q       <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            if_rvalid_q <= fire && !owner_ls;
            ls_rvalid_q <= fire && owner_ls;
            ls_err_q    <= fire && owner_ls && err_q;

            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (ls_gnt && !starved)
                starve_cnt <= starve_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (if_gnt || ls_gnt) begin
                        state    <= ISSUE;
                        owner_ls <= ls_gnt;
                        if (if_gnt) begin
                            err_q     <= 1'b0;
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_be    <= 4'b1111;
                            mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= '0;
                        end else begin
                            err_q     <= ls_misalign;
                            mem_en    <= !ls_misalign;
                            mem_we    <= ls_we && !ls_misalign;
                            mem_be    <= ls_misalign ? 4'b0000 : ls_be;
                            mem_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= (ls_we && !ls_misalign) ? ls_lanes : '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_be    <= '0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    lat_cnt   <= CNT_W'(MEM_LAT - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= IDLE;
                        if (!owner_ls)
                            if_rdata_q <= mem_rdata;
                        else if (!err_q)
                            ls_rdata_q <= mem_rdata;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_err    = ls_err_q;
    assign if_rdata  = if_rvalid_q ? mem_rdata : if_rdata_q;
    assign ls_rdata  = (ls_rvalid_q && !ls_err_q) ? mem_rdata : ls_rdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_port_arbiter: directed vectors plus randomized
// request traffic against a transaction-level timing model.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;
    logic [139:0] all_out;

    int checks = 0;
    int failures = 0;
    logic [31:0] if_rdata_exp = '0;
    logic [31:0] ls_rdata_exp = '0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    assign all_out = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
                      mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0000_0100) return 32'h0000_0013;
        return (w * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic ls_bad(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (int'(a[1:0]) % (1 << sz)) != 0;
    endfunction

    // Memory returns the addressed word MEM_LAT cycles after a strobe, noise otherwise.
    logic [31:0] rd_pipe [MEM_LAT];
    always @(posedge clock) begin
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem_en ? mem_word(mem_addr) : $urandom;
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic test_reset();
        reset_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h40; ls_addr = 32'h80;
        repeat (2) @(negedge clock);
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h required 0", all_out);
        end
        @(posedge clock); #1; if_req = 1'b0; ls_req = 1'b0; reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_idle got=%h required 0", all_out);
        end
        if_rdata_exp = '0; ls_rdata_exp = '0;
    endtask

    task automatic test_fetch();
        logic [31:0] a;
        for (int n = 0; n < 6; n++) begin
            a = (n == 0) ? 32'h0000_0103 : $urandom;
            @(posedge clock); #1; if_req = 1'b1; if_addr = a;
            @(negedge clock);
            checks++;
            if ({if_gnt, ls_gnt} !== 2'b10) begin
                failures++; $display("FAIL fetch_gnt if/ls=%b required 10", {if_gnt, ls_gnt});
            end
            @(posedge clock); #1; if_req = 1'b0; if_addr = $urandom;
            @(negedge clock);
            checks++;
            if ({mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, a & 32'hFFFF_FFFC}) begin
                failures++;
                $display("FAIL fetch_issue en=%b we=%b be=%b addr=%h required 1 0 1111 %h",
                         mem_en, mem_we, mem_be, mem_addr, a & 32'hFFFF_FFFC);
            end
            for (int k = 1; k < MEM_LAT; k++) begin
                @(negedge clock);
                checks++;
                if ({if_rvalid, mem_en, busy} !== 3'b001) begin
                    failures++; $display("FAIL fetch_wait rvalid/en/busy=%b required 001", {if_rvalid, mem_en, busy});
                end
            end
            @(negedge clock);
            if_rdata_exp = mem_word(a);
            checks++;
            if ({if_rvalid, ls_rvalid, if_rdata} !== {2'b10, if_rdata_exp}) begin
                failures++;
                $display("FAIL fetch_rvalid rvalid=%b ls_rvalid=%b rdata=%h required 1 0 %h",
                         if_rvalid, ls_rvalid, if_rdata, if_rdata_exp);
            end
            @(negedge clock);
            checks++;
            if ({if_rvalid, busy, if_rdata} !== {2'b00, if_rdata_exp}) begin
                failures++;
                $display("FAIL fetch_hold rvalid=%b busy=%b rdata=%h required 0 0 %h", if_rvalid, busy, if_rdata, if_rdata_exp);
            end
        end
    endtask

    task automatic test_ls();
        logic [31:0] a, wd, lanes;
        logic [3:0]  be;
        logic [1:0]  sz;
        logic        we, err;
        int          nb, off;
        for (int n = 0; n < 20; n++) begin
            case (n)
                0:       begin sz = 2'd0; we = 1'b1; a = 32'h202; wd = 32'hAB; end
                1:       begin sz = 2'd1; we = 1'b1; a = 32'h201; wd = $urandom; end
                2:       begin sz = 2'd2; we = 1'b1; a = 32'h204; wd = $urandom; end
                default: begin
                    sz = 2'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1));
                    a = $urandom; wd = $urandom;
                end
            endcase
            nb  = 1 << sz;
            off = (sz == 2'd3) ? 0 : (int'(a[1:0]) / nb) * nb;
            err = ls_bad(sz, a);
            be = '0; lanes = '0;
            for (int j = 0; j < 4; j++) begin
                if (j >= off && j < off + nb) be[j] = 1'b1;
                lanes[8*j +: 8] = wd[8*(j % nb) +: 8];
            end
            @(posedge clock); #1;
            ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
            @(negedge clock);
            checks++;
            if ({if_gnt, ls_gnt} !== 2'b01) begin
                failures++; $display("FAIL ls_gnt if/ls=%b required 01", {if_gnt, ls_gnt});
            end
            @(posedge clock); #1; ls_req = 1'b0; ls_addr = $urandom; ls_wdata = $urandom;
            @(negedge clock);
            checks++;
            if (err) begin
                if ({mem_en, mem_we} !== 2'b00) begin
                    failures++; $display("FAIL ls_err_issue en/we=%b required 00 (size %0d addr %h)", {mem_en, mem_we}, sz, a);
                end
            end else if ({mem_en, mem_we, mem_be, mem_addr} !== {1'b1, we, be, a & 32'hFFFF_FFFC} ||
                         (we && mem_wdata !== lanes)) begin
                failures++;
                $display("FAIL ls_issue en=%b we=%b be=%b addr=%h wdata=%h required 1 %b %b %h %h",
                         mem_en, mem_we, mem_be, mem_addr, mem_wdata, we, be, a & 32'hFFFF_FFFC, lanes);
            end
            for (int k = 1; k < MEM_LAT; k++) begin
                @(negedge clock);
                checks++;
                if ({ls_rvalid, mem_en} !== 2'b00) begin
                    failures++; $display("FAIL ls_wait rvalid/en=%b required 00", {ls_rvalid, mem_en});
                end
            end
            @(negedge clock);
            if (!err) ls_rdata_exp = mem_word(a);
            checks++;
            if ({ls_rvalid, ls_err, if_rvalid, ls_rdata} !== {1'b1, err, 1'b0, ls_rdata_exp}) begin
                failures++;
                $display("FAIL ls_done rvalid=%b err=%b if_rvalid=%b rdata=%h required 1 %b 0 %h",
                         ls_rvalid, ls_err, if_rvalid, ls_rdata, err, ls_rdata_exp);
            end
            @(negedge clock);
            checks++;
            if ({ls_rvalid, ls_err, busy, ls_rdata} !== {3'b000, ls_rdata_exp}) begin
                failures++;
                $display("FAIL ls_hold rvalid=%b err=%b busy=%b rdata=%h required 0 0 0 %h",
                         ls_rvalid, ls_err, busy, ls_rdata, ls_rdata_exp);
            end
        end
    endtask

    task automatic test_simul();
        logic [31:0] ia, la;
        ia = $urandom; la = $urandom & 32'hFFFF_FFFC;
        @(posedge clock); #1;
        if_req = 1'b1; if_addr = ia;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = la;
        @(negedge clock);
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b01) begin
            failures++; $display("FAIL simul_first if/ls=%b required 01", {if_gnt, ls_gnt});
        end
        @(posedge clock); #1; ls_req = 1'b0;
        for (int k = 1; k <= MEM_LAT + 1; k++) begin
            @(negedge clock);
            checks++;
            if ({if_gnt, ls_gnt, ls_rvalid} !== {2'b00, k == MEM_LAT + 1}) begin
                failures++;
                $display("FAIL simul_wait k=%0d if/ls/rvalid=%b required 00%b", k, {if_gnt, ls_gnt, ls_rvalid}, k == MEM_LAT + 1);
            end
        end
        @(negedge clock);
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            failures++; $display("FAIL simul_second if/ls=%b required 10", {if_gnt, ls_gnt});
        end
        @(posedge clock); #1; if_req = 1'b0;
        repeat (MEM_LAT + 3) @(posedge clock);
        ls_rdata_exp = mem_word(la); if_rdata_exp = mem_word(ia);
    endtask

    task automatic test_starvation();
        logic [31:0] ia, la;
        int grants, last_t;
        logic exp_if;
        ia = $urandom; la = $urandom & 32'hFFFF_FFFC;
        grants = 0; last_t = 0;
        @(posedge clock); #1;
        if_req = 1'b1; if_addr = ia;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = la;
        for (int t = 0; t < 12 * (MEM_LAT + 2) && grants < 12; t++) begin
            @(negedge clock);
            if (if_gnt || ls_gnt) begin
                exp_if = (grants % (STARVE_MAX + 1)) == STARVE_MAX;
                checks++;
                if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin
                    failures++; $display("FAIL starve_order grant#%0d if/ls=%b required %b%b", grants, {if_gnt, ls_gnt}, exp_if, !exp_if);
                end
                if (grants > 0) begin
                    checks++;
                    if (t - last_t != MEM_LAT + 2) begin
                        failures++; $display("FAIL starve_spacing grant#%0d gap=%0d required %0d", grants, t - last_t, MEM_LAT + 2);
                    end
                end
                last_t = t;
                grants++;
            end
        end
        checks++;
        if (grants != 12) begin
            failures++; $display("FAIL starve_budget grants=%0d required 12", grants);
        end
        @(posedge clock); #1; if_req = 1'b0; ls_req = 1'b0;
        repeat (MEM_LAT + 3) @(posedge clock);
        if_rdata_exp = mem_word(ia); ls_rdata_exp = mem_word(la);
    endtask

    task automatic test_random();
        int free_at, starve, pend_t;
        logic pend_ls, pend_err, got_if, got_ls, e_if, e_ls, pv;
        logic [31:0] pend_data;
        free_at = 0; starve = 0; pend_t = -1; pend_ls = 1'b0; pend_err = 1'b0; pend_data = '0;
        got_if = 1'b0; got_ls = 1'b0;
        for (int t = 0; t < 420; t++) begin
            @(posedge clock); #1;
            if (got_if) if_req = 1'b0;
            else if (t < 400 && !if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (got_ls) ls_req = 1'b0;
            else if (t < 400 && !ls_req && $urandom_range(0, 2) == 0) begin
                ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_size = 2'($urandom_range(0, 3));
                ls_addr = $urandom; ls_wdata = $urandom;
            end
            @(negedge clock);
            e_if = (t >= free_at) && if_req && (!ls_req || starve == STARVE_MAX);
            e_ls = (t >= free_at) && ls_req && !e_if;
            checks++;
            if ({if_gnt, ls_gnt} !== {e_if, e_ls}) begin
                failures++; $display("FAIL rand_gnt t=%0d if/ls=%b required %b%b", t, {if_gnt, ls_gnt}, e_if, e_ls);
            end
            pv = (t == pend_t);
            checks++;
            if ({if_rvalid, ls_rvalid, ls_err} !== {pv && !pend_ls, pv && pend_ls, pv && pend_ls && pend_err}) begin
                failures++;
                $display("FAIL rand_rvalid t=%0d if/ls/err=%b required %b%b%b", t, {if_rvalid, ls_rvalid, ls_err},
                         pv && !pend_ls, pv && pend_ls, pv && pend_ls && pend_err);
            end
            if (pv) begin
                if (!pend_ls) if_rdata_exp = pend_data;
                else if (!pend_err) ls_rdata_exp = pend_data;
                checks++;
                if (if_rdata !== if_rdata_exp || ls_rdata !== ls_rdata_exp) begin
                    failures++;
                    $display("FAIL rand_rdata t=%0d if=%h ls=%h required %h %h", t, if_rdata, ls_rdata, if_rdata_exp, ls_rdata_exp);
                end
            end
            if (!if_req || e_if) starve = 0;
            else if (e_ls && starve < STARVE_MAX) starve++;
            got_if = e_if; got_ls = e_ls;
            if (e_if || e_ls) begin
                free_at   = t + MEM_LAT + 2;
                pend_t    = t + MEM_LAT + 1;
                pend_ls   = e_ls;
                pend_err  = e_ls && ls_bad(ls_size, ls_addr);
                pend_data = mem_word(e_ls ? ls_addr : if_addr);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] la;
        la = $urandom & 32'hFFFF_FFFC;
        @(posedge clock); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = la;
        @(negedge clock);
        checks++;
        if (ls_gnt !== 1'b1) begin
            failures++; $display("FAIL rst_mid_gnt ls_gnt=%b required 1", ls_gnt);
        end
        @(posedge clock); #1;
        @(posedge clock); #2; reset_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL rst_mid_async got=%h required 0", all_out);
        end
        @(negedge clock); @(negedge clock);
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL rst_mid_no_rvalid got=%h required 0", all_out);
        end
        @(posedge clock); #1; reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b01) begin
            failures++; $display("FAIL rst_mid_regrant if/ls=%b required 01", {if_gnt, ls_gnt});
        end
        @(posedge clock); #1; ls_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, la}) begin
            failures++; $display("FAIL rst_mid_issue en=%b addr=%h required 1 %h", mem_en, mem_addr, la);
        end
        repeat (MEM_LAT) @(negedge clock);
        checks++;
        if ({ls_rvalid, ls_rdata, if_rdata} !== {1'b1, mem_word(la), 32'h0}) begin
            failures++;
            $display("FAIL rst_mid_done rvalid=%b rdata=%h if_rdata=%h required 1 %h 0", ls_rvalid, ls_rdata, if_rdata, mem_word(la));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_ls();
        test_simul();
        test_starvation();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
